// File: rtl/quad_tx.sv
// quad_tx: turns signed step requests into A/B quadrature waveforms.
// Define QUAD_TX_BOUNCE_EN to add contact bounce after each transition.
module quad_tx #(
  parameter int PHASE_CYCLES   = 4,
  parameter int EDGES_PER_STEP = 4,
  parameter int MAX_PENDING    = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic step_valid,
  input  logic step_dir,
  output logic step_ready,
  output logic a,
  output logic b,
  output logic busy
);

  localparam int PW = $clog2(MAX_PENDING) + 2;
  localparam int EW = $clog2(EDGES_PER_STEP + 1);
  localparam int TW = $clog2(PHASE_CYCLES);

  // state bits are {a,b}, so the gray sequence is the encoding
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b01
  } ph_t;

  function automatic ph_t ph_step(ph_t s, logic d);
    ph_t n;
    n = s;
    unique case (s)
      S0: n = d ? S1 : S3;
      S1: n = d ? S2 : S0;
      S2: n = d ? S3 : S1;
      S3: n = d ? S0 : S2;
    endcase
    return n;
  endfunction

  logic signed [PW-1:0] r_pend;
  logic [EW-1:0]        r_edges;
  logic [TW-1:0]        r_timer;
  logic                 r_dir;
  ph_t                  r_ph;
  logic                 r_a;
  logic                 r_b;
  logic                 r_busy;

  logic [PW-1:0]        w_mag;
  logic                 w_acc;
  logic                 w_start;
  logic                 w_trans;
  logic                 w_dir_n;
  logic signed [PW-1:0] w_req;
  logic signed [PW-1:0] w_dec;
  logic signed [PW-1:0] w_pend_n;
  logic [EW-1:0]        w_edges_n;
  logic [TW-1:0]        w_timer_n;
  ph_t                  w_ph_n;
  logic                 w_a_n;
  logic                 w_b_n;
  logic                 w_busy_n;

`ifdef QUAD_TX_BOUNCE_EN
  logic [2:0] r_bcnt;
  logic       r_bch;
  logic [2:0] w_bcnt_n;
  logic       w_bch_n;
`endif

  assign step_ready = w_mag < PW'(MAX_PENDING);
  assign a          = r_a;
  assign b          = r_b;
  assign busy       = r_busy;

  // magnitude of the queue, step acceptance and step start
  always_comb begin
    w_mag   = r_pend[PW-1] ? $unsigned(-r_pend)
                           : $unsigned(r_pend);
    w_acc   = step_valid & step_ready;
    w_start = (r_edges == '0) && (r_timer == '0)
              && (r_pend != '0);
    w_trans = w_start
              || ((r_edges != '0) && (r_timer == '0));
    w_dir_n = w_start ? ~r_pend[PW-1] : r_dir;
  end

  // next-state values for queue, counters and phase
  always_comb begin
    w_req = '0;
    if (w_acc)
      w_req = step_dir ? PW'(1) : '1;
    w_dec = '0;
    if (w_start)
      w_dec = r_pend[PW-1] ? '1 : PW'(1);
    w_pend_n = r_pend + w_req - w_dec;

    w_edges_n = r_edges;
    if (w_start)
      w_edges_n = EW'(EDGES_PER_STEP - 1);
    else if (w_trans)
      w_edges_n = r_edges - EW'(1);

    w_timer_n = r_timer;
    if (w_trans)
      w_timer_n = TW'(PHASE_CYCLES - 1);
    else if (r_timer != '0)
      w_timer_n = r_timer - TW'(1);

    w_ph_n = w_trans ? ph_step(r_ph, w_dir_n) : r_ph;

    w_busy_n = (w_pend_n != '0) || (w_edges_n != '0)
               || (w_timer_n != '0);
  end

`ifdef QUAD_TX_BOUNCE_EN
  // changed channel toggles back to its old value on odd counts
  always_comb begin
    w_bcnt_n = r_bcnt;
    if (w_trans)
      w_bcnt_n = 3'd4;
    else if (r_bcnt != 3'd0)
      w_bcnt_n = r_bcnt - 3'd1;
    w_bch_n = w_trans ? (w_ph_n[1] != r_ph[1]) : r_bch;
    w_a_n = w_ph_n[1] ^ (w_bch_n & w_bcnt_n[0]);
    w_b_n = w_ph_n[0] ^ (~w_bch_n & w_bcnt_n[0]);
  end
`else
  // clean outputs follow the phase state directly
  always_comb begin
    w_a_n = w_ph_n[1];
    w_b_n = w_ph_n[0];
  end
`endif

  // generator state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_edges <= '0;
      r_timer <= '0;
      r_dir   <= 1'b0;
      r_ph    <= S0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
`ifdef QUAD_TX_BOUNCE_EN
      r_bcnt  <= 3'd0;
      r_bch   <= 1'b0;
`endif
    end else begin
      r_pend  <= w_pend_n;
      r_edges <= w_edges_n;
      r_timer <= w_timer_n;
      r_dir   <= w_dir_n;
      r_ph    <= w_ph_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_busy  <= w_busy_n;
`ifdef QUAD_TX_BOUNCE_EN
      r_bcnt  <= w_bcnt_n;
      r_bch   <= w_bch_n;
`endif
    end
  end

endmodule

// File: tb/tb_quad_tx.sv
// tb_quad_tx: table, directed and random checks for quad_tx.
// Reference model works on edge times rather than counters.
module tb_quad_tx;

`ifdef QUAD_TX_BOUNCE_EN
  localparam int P   = 8;
  localparam bit BNC = 1'b1;
  localparam int CH  = 5;
`else
  localparam int P   = 4;
  localparam bit BNC = 1'b0;
  localparam int CH  = 1;
`endif
  localparam int E    = 4;
  localparam int MAXP = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step_valid = 1'b0;
  logic step_dir = 1'b0;
  logic step_ready;
  logic a;
  logic b;
  logic busy;

  always #5 clk = ~clk;

  quad_tx #(
    .PHASE_CYCLES(P),
    .EDGES_PER_STEP(E),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_valid(step_valid),
    .step_dir(step_dir),
    .step_ready(step_ready),
    .a(a),
    .b(b),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // reference model: edge-time view of the generator
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int m_pend, m_ph, m_dir, m_rem, m_tlast, m_chg;
  int cyc = 0;
  logic [1:0] e_ab;
  logic e_busy, e_rdy;
  logic [1:0] prev_ab;
  int tr_q [$];

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ph = 0; m_dir = 1; m_rem = 0;
    m_tlast = -1000; m_chg = 0;
    prev_ab = 2'b00;
    tr_q.delete();
  endtask

  task automatic model_edge(input bit v, input bit d);
    bit acc;
    logic [1:0] old;
    int dt;
    acc = v && (iabs(m_pend) < MAXP);
    if (cyc >= m_tlast + P) begin
      if (m_rem == 0 && m_pend != 0) begin
        m_dir = (m_pend > 0);
        m_pend = m_pend - ((m_pend > 0) ? 1 : -1);
        m_rem = E;
      end
      if (m_rem > 0) begin
        old = ab_tab[m_ph];
        m_ph = (m_ph + (m_dir ? 1 : 3)) % 4;
        m_chg = (old[1] != ab_tab[m_ph][1]) ? 0 : 1;
        m_rem--;
        m_tlast = cyc;
      end
    end
    if (acc) m_pend = m_pend + (d ? 1 : -1);
    e_ab = ab_tab[m_ph];
    dt = cyc - m_tlast;
    if (BNC && (dt == 1 || dt == 3)) begin
      if (m_chg == 0) e_ab[1] = ~e_ab[1];
      else            e_ab[0] = ~e_ab[0];
    end
    e_busy = (m_pend != 0) || (m_rem != 0)
             || (cyc < m_tlast + P - 1);
    e_rdy = iabs(m_pend) < MAXP;
  endtask

  task automatic tick();
    bit v, d;
    v = step_valid;
    d = step_dir;
    @(posedge clk);
    cyc++;
    model_edge(v, d);
    #1;
    chk("model_ab", {a, b}, e_ab);
    chk("model_busy", busy, e_busy);
    chk("model_ready", step_ready, e_rdy);
    if ({a, b} !== prev_ab) tr_q.push_back(cyc);
    prev_ab = {a, b};
  endtask

  task automatic do_reset();
    step_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("reset_ab", {a, b}, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", step_ready, 1'b1);
  endtask

  typedef struct {
    bit dir;
    int ed;
    logic [1:0] ab;
    logic bsy;
    logic rdy;
  } vec_t;

  vec_t tv [$];
  bit exp_a [8] = '{1, 0, 1, 0, 1, 1, 1, 1};

  initial begin
    int base, last, lim;
    tv.push_back('{1, 9, 2'b00, 0, 1});
    tv.push_back('{1, 10, 2'b00, 1, 1});
    tv.push_back('{1, 11, 2'b10, 1, 1});
    tv.push_back('{1, 14, 2'b10, 1, 1});
    tv.push_back('{1, 15, 2'b11, 1, 1});
    tv.push_back('{1, 19, 2'b01, 1, 1});
    tv.push_back('{1, 23, 2'b00, 1, 1});
    tv.push_back('{1, 25, 2'b00, 1, 1});
    tv.push_back('{1, 26, 2'b00, 0, 1});
    tv.push_back('{0, 10, 2'b00, 1, 1});
    tv.push_back('{0, 11, 2'b01, 1, 1});
    tv.push_back('{0, 15, 2'b11, 1, 1});
    tv.push_back('{0, 19, 2'b10, 1, 1});
    tv.push_back('{0, 23, 2'b00, 1, 1});
    tv.push_back('{0, 26, 2'b00, 0, 1});

    model_reset();

`ifndef QUAD_TX_BOUNCE_EN
    // single steps, both directions, against the table
    for (int dir = 1; dir >= 0; dir--) begin
      do_reset();
      for (int e = 1; e <= 28; e++) begin
        step_valid = (e == 10);
        step_dir = dir[0];
        tick();
        foreach (tv[i]) begin
          if (tv[i].dir == dir[0] && tv[i].ed == e) begin
            chk("tbl_ab", {a, b}, tv[i].ab);
            chk("tbl_busy", busy, tv[i].bsy);
            chk("tbl_ready", step_ready, tv[i].rdy);
          end
        end
      end
    end
`endif

    // cancel: +1 at 10, +1 at 12, -1 at 13
    do_reset();
    lim = 11 + E * P + 4;
    for (int e = 1; e <= lim; e++) begin
      step_valid = (e == 10 || e == 12 || e == 13);
      step_dir = (e != 13);
      tick();
      if (e == 11 + E * P - 2)
        chk("cancel_busy_hi", busy, 1'b1);
      if (e == 11 + E * P - 1)
        chk("cancel_busy_lo", busy, 1'b0);
    end
    chk("cancel_trans", 4'(tr_q.size()), 4'(4 * CH));
    chk("cancel_ab", {a, b}, 2'b00);

    // saturate the queue with a held request
    do_reset();
    base = cyc;
    last = 11 + (E * 8 - 1) * P;
    for (int e = 1; e <= last + P + 2; e++) begin
      step_valid = (e >= 10 && e <= 27 + E * (P - 4));
      step_dir = 1'b1;
      tick();
      if (e == 16) chk("sat_rdy16", step_ready, 1'b1);
      if (e == 17) chk("sat_rdy17", step_ready, 1'b0);
      if (e == 10 + E * P)
        chk("sat_rdy_low", step_ready, 1'b0);
      if (e == 11 + E * P)
        chk("sat_rdy_back", step_ready, 1'b1);
      if (e == last + P - 2)
        chk("sat_busy_hi", busy, 1'b1);
      if (e == last + P - 1)
        chk("sat_busy_lo", busy, 1'b0);
    end
    chk("sat_trans", 8'(tr_q.size()), 8'(32 * CH));
`ifndef QUAD_TX_BOUNCE_EN
    if (tr_q.size() > 0)
      chk("sat_first", 8'(tr_q[0] - base), 8'd11);
    for (int i = 1; i < tr_q.size(); i++)
      chk("sat_space", 4'(tr_q[i] - tr_q[i-1]), 4'(P));
`endif

    // asynchronous reset in the middle of a step
    do_reset();
    for (int e = 1; e <= 11 + 2 * P - 1; e++) begin
      step_valid = (e == 10);
      step_dir = 1'b1;
      tick();
    end
    chk("mid_ab11", {a, b}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("async_ab", {a, b}, 2'b00);
    chk("async_busy", busy, 1'b0);
    chk("async_ready", step_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int e = 0; e < 20; e++) tick();
    chk("after_rst_trans", 4'(tr_q.size()), 4'd0);

`ifdef QUAD_TX_BOUNCE_EN
    // bounce pattern on A after the first transition
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      step_valid = (e == 10);
      step_dir = 1'b1;
      tick();
      if (e >= 11) begin
        chk("bounce_a", a, exp_a[e-11]);
        chk("bounce_b", b, 1'b0);
      end
    end
    for (int e = 0; e < 40; e++) tick();
`endif

    // random traffic with occasional asynchronous resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int pct;
      pct = ((n / 400) % 3 == 0) ? 70 :
            ((n / 400) % 3 == 1) ? 15 : 40;
      step_valid = ($urandom_range(0, 99) < pct);
      step_dir = $urandom_range(0, 1) == 1;
      tick();
      if ($urandom_range(0, 999) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        chk("rnd_rst_ab", {a, b}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
      end
    end
    step_valid = 1'b0;
    for (int n = 0; n < 80 * P; n++) tick();
    chk("rnd_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
